cpu_fetch_queue: RTL and testbench

CPU_FETCH_QUEUE -- requirements
Module: cpu_fetch_queue

---
 rtl/cpu_fetch_queue_pkg.sv | 25 ++
 rtl/cpu_fetch_queue_if.sv | 34 +++
 rtl/cpu_fetch_fifo.sv | 62 ++++++
 rtl/cpu_fetch_queue.sv | 155 +++++++++++++++
 tb/tb_cpu_fetch_queue.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_fetch_queue_pkg
//  Brief   : Shared widths, queue-entry type and PC helper for the fetch queue
//  Revision: 1.0 - initial release
// ============================================================================
package cpu_fetch_queue_pkg;

    localparam int unsigned c_PC_WIDTH          = 32;
    localparam int unsigned c_BUS_WIDTH_DEFAULT = 32;
    localparam logic [c_PC_WIDTH-1:0] c_PC_STEP = 32'd4;

    // One prefetched instruction together with the address it came from
    typedef struct packed {
        logic [c_PC_WIDTH-1:0]          pc;
        logic [c_BUS_WIDTH_DEFAULT-1:0] word;
    } fetch_entry_t;

    // Sequential (not-taken) successor of a fetch address
    function automatic logic [c_PC_WIDTH-1:0] next_pc(input logic [c_PC_WIDTH-1:0] pc);
        return pc + c_PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_fetch_queue_if
//  Brief   : Fetch bus and consumer handshake bundle of the fetch queue
//  Revision: 1.0 - initial release
// ============================================================================
interface cpu_fetch_queue_if #(
    parameter int unsigned BUS_WIDTH = cpu_fetch_queue_pkg::c_BUS_WIDTH_DEFAULT
);
    import cpu_fetch_queue_pkg::*;

    logic                  bus_request;
    logic [c_PC_WIDTH-1:0] bus_address;
    logic                  bus_ready;
    logic [BUS_WIDTH-1:0]  bus_rdata;
    logic                  valid;
    logic                  ready;
    logic [BUS_WIDTH-1:0]  instruction;
    logic [c_PC_WIDTH-1:0] pc;

    // Fetch-unit side: drives the bus request and the queue head
    modport master (
        output bus_request, bus_address, valid, instruction, pc,
        input  bus_ready, bus_rdata, ready
    );

    // Memory / consumer side
    modport slave (
        input  bus_request, bus_address, valid, instruction, pc,
        output bus_ready, bus_rdata, ready
    );

endinterface
`default_nettype wire

// File: rtl/cpu_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_fetch_fifo
//  Brief   : Prefetch queue storage and pointers; exposes head and next entry
//  Revision: 1.0 - initial release
// ============================================================================
module cpu_fetch_fifo
    import cpu_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         ENTRY_T = fetch_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  ENTRY_T                 push_data_i,
    input  logic                   pop_i,
    output ENTRY_T                 head_o,
    output ENTRY_T                 next_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    // The caller never pushes when full nor pops when empty
    ENTRY_T           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W:0]   count_q;

    assign w_rd_next = rd_ptr_q + 1'b1;

    // Pointer and occupancy update; clear empties the queue in one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= w_rd_next;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (!push_i && pop_i) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage needs no reset: occupancy alone says what is live
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[w_rd_next];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_fetch_queue
//  Brief   : Sequential instruction prefetcher with jump flush and IRQ dispatch
//  Revision: 1.0 - initial release
// ============================================================================
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BUS_WIDTH    = c_BUS_WIDTH_DEFAULT
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_jump,
    input  logic [31:0]            i_jump_pc,
    input  logic                   i_irq_pending,
    input  logic [31:0]            i_irq_pc,
    output logic                   o_irq_dispatched,
    output logic [31:0]            o_irq_epc,
    output logic                   o_bus_request,
    input  logic                   i_bus_ready,
    output logic [31:0]            o_bus_address,
    input  logic [BUS_WIDTH-1:0]   i_bus_rdata,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BUS_WIDTH-1:0]   o_instruction,
    output logic [31:0]            o_pc,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [31:0]            o_flush_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Same layout as fetch_entry_t, sized to this instance's bus width
    typedef struct packed {
        logic [c_PC_WIDTH-1:0] pc;
        logic [BUS_WIDTH-1:0]  word;
    } entry_t;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic             discard_q, discard_d;
    logic             irq_prev_q;
    logic             irq_disp_q;
    logic [31:0]      irq_epc_q, irq_epc_d;
    logic [31:0]      flush_cnt_q;

    entry_t           w_head, w_next, w_push_entry;
    logic [CNT_W-1:0] w_count, w_count_d;
    logic             w_irq_edge, w_flush, w_complete, w_valid;
    logic             w_pop_req, w_pop, w_push;
    logic [31:0]      w_epc;
    logic             w_unused_next;

    assign w_irq_edge    = i_irq_pending && !irq_prev_q;
    assign w_flush       = i_jump || w_irq_edge;
    assign w_complete    = req_q && i_bus_ready;
    assign w_valid       = (w_count != '0);
    assign w_pop_req     = w_valid && i_ready;
    assign w_pop         = w_pop_req && !w_flush;
    assign w_push        = w_complete && !discard_q && !w_flush;
    assign w_push_entry  = '{pc: addr_q, word: i_bus_rdata};
    assign w_unused_next = ^w_next.word;

    cpu_fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk_i       (i_clock),
        .rst_ni      (i_reset_n),
        .clear_i     (w_flush),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .next_o      (w_next),
        .count_o     (w_count)
    );

    // Next fetch PC, request/discard tracking and interrupt return address
    always_comb begin
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        discard_d = discard_q;
        irq_epc_d = irq_epc_q;
        w_count_d = w_count;

        if (w_flush)                   w_count_d = '0;
        else if (w_push && !w_pop)     w_count_d = w_count + 1'b1;
        else if (!w_push && w_pop)     w_count_d = w_count - 1'b1;

        if (w_flush) begin
            pc_d      = w_irq_edge ? i_irq_pc : i_jump_pc;
            // An in-flight word from the old stream must be dropped on arrival
            discard_d = req_q && !i_bus_ready;
        end else if (w_complete) begin
            if (!discard_q) pc_d = next_pc(pc_q);
            discard_d = 1'b0;
        end

        // Hold a pending request; otherwise issue one whenever a slot is free
        if (req_q && !i_bus_ready) begin
            req_d = 1'b1;
        end else begin
            req_d  = (w_count_d < CNT_W'(DEPTH));
            addr_d = pc_d;
        end

        // Resume point: the oldest instruction not yet consumed
        if (i_jump)                 w_epc = i_jump_pc;
        else if (!w_valid)          w_epc = pc_q;
        else if (w_pop_req)         w_epc = (w_count > CNT_W'(1)) ? w_next.pc : pc_q;
        else                        w_epc = w_head.pc;

        if (w_irq_edge) irq_epc_d = w_epc;
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q        <= RESET_VECTOR;
            addr_q      <= RESET_VECTOR;
            req_q       <= 1'b0;
            discard_q   <= 1'b0;
            irq_prev_q  <= 1'b0;
            irq_disp_q  <= 1'b0;
            irq_epc_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            discard_q   <= discard_d;
            irq_prev_q  <= i_irq_pending;
            irq_disp_q  <= w_irq_edge;
            irq_epc_q   <= irq_epc_d;
            if (w_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_bus_request    = req_q;
    assign o_bus_address    = addr_q;
    assign o_valid          = w_valid;
    assign o_instruction    = w_head.word;
    assign o_pc             = w_head.pc;
    assign o_count          = w_count;
    assign o_flush_count    = flush_cnt_q;
    assign o_irq_dispatched = irq_disp_q;
    assign o_irq_epc        = irq_epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cpu_fetch_queue
//  Brief   : Self-checking bench for cpu_fetch_queue against a queue model
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_fetch_queue;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jpc = '0;
    logic        irq = 1'b0;
    logic [31:0] ipc = '0;
    logic        disp;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic [31:0] fcnt;

    always #5 clk = ~clk;

    cpu_fetch_queue_if #(.BUS_WIDTH(32)) bus_if ();

    cpu_fetch_queue #(.RESET_VECTOR(RV), .DEPTH(DEPTH), .BUS_WIDTH(32)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_jump           (jump),
        .i_jump_pc        (jpc),
        .i_irq_pending    (irq),
        .i_irq_pc         (ipc),
        .o_irq_dispatched (disp),
        .o_irq_epc        (epc),
        .o_bus_request    (bus_if.bus_request),
        .i_bus_ready      (bus_if.bus_ready),
        .o_bus_address    (bus_if.bus_address),
        .i_bus_rdata      (bus_if.bus_rdata),
        .o_valid          (bus_if.valid),
        .i_ready          (bus_if.ready),
        .o_instruction    (bus_if.instruction),
        .o_pc             (bus_if.pc),
        .o_count          (cnt),
        .o_flush_count    (fcnt)
    );

    // Behavioural model: the queue as a list of {pc, word}, plus fetch state
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fpc, m_addr, m_epc, m_fcnt;
    bit          m_busy, m_drop, m_prev, m_disp;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    int  bus_mode = 0;   // 0 zero-wait, 1 random wait, 2 never ready
    logic [31:0] comp_addrs[$];
    logic [31:0] pop_pcs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = RV; m_addr = RV; m_epc = '0; m_fcnt = '0;
        m_busy = 0; m_drop = 0; m_prev = 0; m_disp = 0;
    endtask

    // One clock of the model, from the inputs about to be sampled
    task automatic model_step();
        bit edge_v, flush_v, comp_v;
        edge_v  = irq && !m_prev;
        flush_v = jump || edge_v;
        comp_v  = m_busy && bus_if.bus_ready;
        m_disp  = edge_v;
        if (edge_v) begin
            if (jump)                m_epc = jpc;
            else if (mq.size() == 0) m_epc = m_fpc;
            else if (bus_if.ready)   m_epc = (mq.size() > 1) ? mq[1].pc : m_fpc;
            else                     m_epc = mq[0].pc;
        end
        if (flush_v) begin
            mq.delete();
            m_fpc  = edge_v ? ipc : jpc;
            m_fcnt = m_fcnt + 32'd1;
            if (comp_v) begin m_busy = 0; m_drop = 0; end
            else if (m_busy) m_drop = 1;
        end else begin
            if (mq.size() > 0 && bus_if.ready) void'(mq.pop_front());
            if (comp_v) begin
                if (!m_drop) begin
                    mq.push_back('{pc: m_fpc, word: bus_if.bus_rdata});
                    m_fpc = m_fpc + 32'd4;
                end
                m_busy = 0; m_drop = 0;
            end
        end
        if (!m_busy && mq.size() < DEPTH) begin m_busy = 1; m_addr = m_fpc; end
        m_prev = irq;
    endtask

    // Compare process: DUT outputs against the model on every clock
    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_request", {31'b0, bus_if.bus_request}, {31'b0, m_busy});
            if (m_busy) check("bus_address", bus_if.bus_address, m_addr);
            check("count", {29'b0, cnt}, 32'(mq.size()));
            check("valid", {31'b0, bus_if.valid}, {31'b0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                check("head_pc", bus_if.pc, mq[0].pc);
                check("head_word", bus_if.instruction, mq[0].word);
            end
            check("flush_count", fcnt, m_fcnt);
            check("irq_dispatched", {31'b0, disp}, {31'b0, m_disp});
            check("irq_epc", epc, m_epc);
        end
    end

    // Drive the bus responder, step the model, advance one clock
    task automatic tick();
        case (bus_mode)
            0:       bus_if.bus_ready = bus_if.bus_request;
            1:       bus_if.bus_ready = bus_if.bus_request && ($urandom_range(0, 2) == 0);
            default: bus_if.bus_ready = 1'b0;
        endcase
        bus_if.bus_rdata = $urandom;
        if (bus_if.bus_request && bus_if.bus_ready) comp_addrs.push_back(bus_if.bus_address);
        if (bus_if.valid && bus_if.ready) pop_pcs.push_back(bus_if.pc);
        model_step();
        @(negedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " bus_request"}, {31'b0, bus_if.bus_request}, 32'd0);
        check({tag, " count"}, {29'b0, cnt}, 32'd0);
        check({tag, " valid"}, {31'b0, bus_if.valid}, 32'd0);
        check({tag, " irq_dispatched"}, {31'b0, disp}, 32'd0);
        check({tag, " irq_epc"}, epc, 32'd0);
        check({tag, " flush_count"}, fcnt, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit found;
        model_reset();
        bus_if.ready = 1'b0; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");

        // Release; the first clock must raise a request at the reset vector
        rst_n = 1'b1; chk_en = 1'b1; bus_mode = 0;
        tick();
        check("first request", {31'b0, bus_if.bus_request}, 32'd1);
        check("first address", bus_if.bus_address, 32'h100);

        // Fill with the consumer stalled
        repeat (12) tick();
        check("fill count", {29'b0, cnt}, 32'd4);
        check("fill bus_request", {31'b0, bus_if.bus_request}, 32'd0);
        check("fill transfers", 32'(comp_addrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < comp_addrs.size(); i++)
            check("fill address", comp_addrs[i], 32'h100 + 32'(4 * i));

        // Drain and refill continuously for 8 cycles
        pop_pcs.delete();
        bus_if.ready = 1'b1;
        repeat (8) tick();
        bus_if.ready = 1'b0;
        check("stream pops", 32'(pop_pcs.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_pcs.size(); i++)
            check("stream pc", pop_pcs[i], 32'h100 + 32'(4 * i));

        // Jump while a transfer is held off for 3 cycles
        check("pre-jump outstanding", {31'b0, bus_if.bus_request}, 32'd1);
        k = comp_addrs.size();
        bus_mode = 2;
        jump = 1'b1; jpc = 32'h400;
        tick();
        jump = 1'b0;
        repeat (2) tick();
        bus_mode = 0;
        repeat (4) tick();
        check("jump resume addr", (comp_addrs.size() > k + 1) ? comp_addrs[k + 1] : 32'hDEAD_BEEF, 32'h400);
        check("jump head pc", bus_if.pc, 32'h400);
        check("jump flush_count", fcnt, 32'd1);

        // Interrupt edge with head at 0x108
        jump = 1'b1; jpc = 32'h108;
        tick();
        jump = 1'b0;
        repeat (8) tick();
        check("irq setup head", bus_if.pc, 32'h108);
        irq = 1'b1; ipc = 32'h800;
        tick();
        check("irq pulse", {31'b0, disp}, 32'd1);
        check("irq epc", epc, 32'h108);
        tick();
        check("irq pulse end", {31'b0, disp}, 32'd0);
        repeat (6) tick();
        check("irq level no redispatch", {31'b0, disp}, 32'd0);
        check("irq head pc", bus_if.pc, 32'h800);
        check("irq flush_count", fcnt, 32'd3);

        // Coincident jump and interrupt edge
        irq = 1'b0;
        tick();
        jump = 1'b1; jpc = 32'h200; irq = 1'b1; ipc = 32'h900;
        tick();
        jump = 1'b0;
        check("coincide pulse", {31'b0, disp}, 32'd1);
        check("coincide epc", epc, 32'h200);
        check("coincide flush_count", fcnt, 32'd4);
        repeat (6) tick();
        check("coincide head pc", bus_if.pc, 32'h900);
        irq = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus_mode     = ($urandom_range(0, 3) == 0) ? 0 : 1;
            bus_if.ready = ($urandom_range(0, 1) == 1);
            jump         = ($urandom_range(0, 15) == 0);
            jpc          = 32'($urandom_range(0, 1023)) << 2;
            ipc          = 32'h8000 + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 9) == 0) irq = ~irq;
            tick();
        end
        jump = 1'b0; irq = 1'b0; bus_if.ready = 1'b0; bus_mode = 0;
        tick();

        // Reset mid-transfer with three entries queued
        jump = 1'b1; jpc = 32'h500;
        tick();
        jump = 1'b0;
        for (int i = 0; i < 20 && !(mq.size() == 3 && m_busy); i++) tick();
        found = (mq.size() == 3 && m_busy);
        check("reset setup reached", {31'b0, found}, 32'd1);
        check("reset setup count", {29'b0, cnt}, 32'd3);
        check("reset setup request", {31'b0, bus_if.bus_request}, 32'd1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        model_reset();
        @(negedge clk); #1;
        rst_n = 1'b1; chk_en = 1'b1; bus_mode = 0;
        tick();
        check("post-reset request", {31'b0, bus_if.bus_request}, 32'd1);
        check("post-reset address", bus_if.bus_address, 32'h100);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
